exu_multicycle: RTL
===================

Name: exu_multicycle

Overview:
Parametrised execution unit, successor to the single-cycle combinational EXU. It executes integer ALU, branch-target, upper-immediate, multiply and divide operations behind valid/ready handshakes on both sides. It sits between IDU and WBU/LSU. Multiply and divide are iterative, so the block has real occupancy. Ebreak and invalid-op are reported as registered result flags, not as side-effect calls.

Parameters:
XLEN, 64, datapath width; 32 or 64.
STEP_BITS, 1, quotient/multiplier bits retired per iteration; must divide XLEN.
OP_W, 5, width of op code.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (asserted when 0)
flush  in  1  abort any in-flight op; drop held result
in_valid  in  1  operation offered
in_ready  out  1  unit can accept
in_op  in  OP_W  operation code (package enum)
in_src1  in  XLEN  operand 1
in_src2  in  XLEN  operand 2 / immediate
in_pc  in  XLEN  pc of instruction
out_valid  out  1  result held
out_ready  in  1  consumer takes result
out_result  out  XLEN  writeback value
out_dnpc  out  XLEN  jump target
out_jump  out  1  out_dnpc valid (JAL/JALR)
out_ebreak  out  1  op was EBREAK
out_invalid  out  1  op not recognised
busy  out  1  iterative op in progress

Behaviour:
- Reset (rst==0 at posedge): state IDLE; out_valid=0, out_result=0, out_dnpc=0, out_jump=0, out_ebreak=0, out_invalid=0, busy=0; in_ready=1 on the cycle after reset releases.
- States: IDLE, MUL, DIV, DONE.
- in_ready = (state==IDLE). Accept = in_valid & in_ready at a posedge; operands are captured.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, AUIPC, LUI, JAL, JALR, SD, EBREAK, invalid): IDLE->DONE. Result is registered, so out_valid rises the cycle after accept (latency 1).
- Op semantics:
  - ADD = src1+src2.
  - AUIPC = src1+pc.
  - LUI = src1.
  - JAL: result = pc+4, dnpc = pc+src1, jump=1.
  - JALR: result = pc+4, dnpc = (src1+src2) & ~1, jump=1.
  - Shifts use src2[log2(XLEN)-1:0].
  - SD: result=0.
  - EBREAK: ebreak=1.
  - Undefined code: invalid=1, result=0.
  - All arithmetic is modulo 2^XLEN.
- MUL (low XLEN bits of the product): IDLE->MUL, then XLEN/STEP_BITS iterations, then DONE.
- DIV/DIVU/REM/REMU: IDLE->DIV, restoring division over XLEN/STEP_BITS iterations on magnitudes, sign fix on exit, then DONE.
- Latency for MUL and all divide ops = XLEN/STEP_BITS + 1 cycles from accept to out_valid (65 at default).
- busy=1 exactly while in MUL or DIV.
- Divide boundary cases:
  - Divide by zero: DIV/DIVU result all-ones; REM/REMU result = src1. Exits after 1 iteration cycle.
  - Signed overflow (src1 = most-negative, src2 = -1): DIV result = src1, REM result = 0.
- DONE: outputs stable while out_valid & ~out_ready. When out_valid & out_ready, go to IDLE and clear out_valid. No same-cycle re-accept: in_ready is 0 in DONE.
- flush=1: next state IDLE, out_valid=0, iteration counter cleared. flush wins over accept and over out_ready in the same cycle.
- Reset mid-iteration: identical to the reset values above; the partial result is discarded.
- in_* values are don't-care when not accepted.

Decomposition:
- Shared package exu_pkg:
  - op enum (OP_ADD...OP_REMU, OP_EBREAK, OP_SD)
  - state enum
  - helper constant ITER = XLEN/STEP_BITS
  - function is_multicycle(op)
- One natural sub-module: exu_divider (start/done handshake; signed/unsigned; quotient and remainder). Keep MUL inline in the top.

Test Plan:
- ADDI: src1=5, src2=7, out_ready=1 -> out_valid one cycle after accept, result=12, jump=0.
- JALR: pc=0x80000000, src1=0x80001001, src2=4 -> result=0x80000004, dnpc=0x80001004, jump=1.
- MUL: src1=0xFFFF_FFFF_FFFF_FFFF, src2=3 -> busy for 64 cycles, out_valid at cycle 65, result=0xFFFF_FFFF_FFFF_FFFD. Hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0.
- Divide corners: DIV src2=0 -> result=0xFFFF_FFFF_FFFF_FFFF; REMU src1=17, src2=0 -> result=17; DIV src1=0x8000_0000_0000_0000, src2=-1 -> result=src1; REM same operands -> result=0; DIVU 100/7 -> result=14.
- Flush at iteration 20 of DIV -> next cycle state IDLE, in_ready=1, out_valid never rises. Reset low at iteration 30 of MUL -> all outputs 0 next cycle.
- Op code 0x1F -> out_invalid=1, result=0. EBREAK -> out_ebreak=1, out_invalid=0. Back-to-back ADD ops with out_ready=1 -> one result every 2 cycles.

Source files
------------

// File: rtl/exu_pkg.sv
// rtl/exu_pkg.sv - shared types, constants and helpers for the multicycle execution unit
// Contents: default widths, iteration count, op code enum, FSM state enum,
//           is_multicycle() classifier and iter_count() helper.
package exu_pkg;

  localparam int XLEN_DEF      = 64;
  localparam int STEP_BITS_DEF = 1;
  localparam int OP_W_DEF      = 5;

  // Iterations an iterative op needs at the default configuration.
  localparam int ITER = XLEN_DEF / STEP_BITS_DEF;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_AUIPC  = 5'd10,
    OP_LUI    = 5'd11,
    OP_JAL    = 5'd12,
    OP_JALR   = 5'd13,
    OP_MUL    = 5'd14,
    OP_DIV    = 5'd15,
    OP_DIVU   = 5'd16,
    OP_REM    = 5'd17,
    OP_REMU   = 5'd18,
    OP_EBREAK = 5'd19,
    OP_SD     = 5'd20
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int iter_count(int xlen, int step_bits);
    return xlen / step_bits;
  endfunction

  function automatic logic is_multicycle(op_e op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_DIVU) ||
           (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/exu_multicycle_if.sv
// rtl/exu_multicycle_if.sv - issue/result handshake bundle between IDU and the EXU
// Signals: in_valid/in_ready/in_op/in_src1/in_src2/in_pc (issue side),
//          out_valid/out_ready/out_result/out_dnpc/out_jump/out_ebreak/out_invalid (result side).
// Modports: master = issuing/consuming agent, slave = execution unit.
interface exu_multicycle_if #(
  parameter int XLEN = 64,
  parameter int OP_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] in_op;
  logic [XLEN-1:0] in_src1;
  logic [XLEN-1:0] in_src2;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [XLEN-1:0] out_dnpc;
  logic            out_jump;
  logic            out_ebreak;
  logic            out_invalid;

  modport master (
    output in_valid, in_op, in_src1, in_src2, in_pc, out_ready,
    input  in_ready, out_valid, out_result, out_dnpc, out_jump, out_ebreak, out_invalid
  );

  modport slave (
    input  in_valid, in_op, in_src1, in_src2, in_pc, out_ready,
    output in_ready, out_valid, out_result, out_dnpc, out_jump, out_ebreak, out_invalid
  );
endinterface

// File: rtl/exu_divider.sv
// rtl/exu_divider.sv - iterative restoring divider, signed/unsigned, quotient and remainder
// Ports: clk, rst (sync active-low), abort_i (drop in-flight op), start_i (load operands),
//        signed_i, dividend_i, divisor_i, done_o (current edge completes the op),
//        quot_o / rem_o (final values, valid while done_o).
module exu_divider
  import exu_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int STEP_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            abort_i,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o
);
  localparam int N_ITER = iter_count(XLEN, STEP_BITS);
  localparam int CW     = (N_ITER > 1) ? $clog2(N_ITER) : 1;

  logic            run_q, dbz_q, neg_q_q, neg_r_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, src1_q;
  logic [XLEN-1:0] rem_d, quo_d;
  logic [XLEN:0]   part;

  logic            s1_neg, s2_neg;
  assign s1_neg = signed_i & dividend_i[XLEN-1];
  assign s2_neg = signed_i & divisor_i[XLEN-1];

  // quo_q starts as the dividend magnitude and is shifted out MSB-first
  // while quotient bits shift in at the bottom.
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    part  = '0;
    for (int i = 0; i < STEP_BITS; i++) begin
      part  = {rem_d, quo_d[XLEN-1]};
      quo_d = {quo_d[XLEN-2:0], 1'b0};
      if (part >= {1'b0, dvs_q}) begin
        part     = part - {1'b0, dvs_q};
        quo_d[0] = 1'b1;
      end
      rem_d = part[XLEN-1:0];
    end
  end

  // Divide-by-zero finishes on its first running cycle.
  assign done_o = run_q & (dbz_q | (cnt_q == CW'(N_ITER - 1)));
  assign quot_o = dbz_q ? '1     : (neg_q_q ? -quo_d : quo_d);
  assign rem_o  = dbz_q ? src1_q : (neg_r_q ? -rem_d : rem_d);

  always_ff @(posedge clk) begin
    if (!rst) begin
      run_q   <= 1'b0;
      dbz_q   <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      src1_q  <= '0;
    end else if (abort_i) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      run_q   <= 1'b1;
      cnt_q   <= '0;
      dbz_q   <= (divisor_i == '0);
      neg_q_q <= s1_neg ^ s2_neg;
      neg_r_q <= s1_neg;
      rem_q   <= '0;
      quo_q   <= s1_neg ? -dividend_i : dividend_i;
      dvs_q   <= s2_neg ? -divisor_i : divisor_i;
      src1_q  <= dividend_i;
    end else if (run_q) begin
      if (done_o) begin
        run_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
        rem_q <= rem_d;
        quo_q <= quo_d;
      end
    end
  end
endmodule

// File: rtl/exu_multicycle.sv
// rtl/exu_multicycle.sv - execution unit: single-cycle ALU/branch ops, iterative MUL and DIV/REM
// Ports: clk, rst (sync active-low), flush (abort in-flight op, drop held result),
//        bus (slave side of exu_multicycle_if: issue and result handshakes),
//        busy (iterative op in progress).
module exu_multicycle
  import exu_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int STEP_BITS = STEP_BITS_DEF,
  parameter int OP_W      = OP_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  exu_multicycle_if.slave bus,
  output logic            busy
);
  localparam int N_ITER = iter_count(XLEN, STEP_BITS);
  localparam int CW     = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam int SHW    = $clog2(XLEN);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] acc_q, mcand_q, mplier_q;
  logic [XLEN-1:0] acc_d, mcand_d, mplier_d;
  logic            rem_sel_q;
  logic            out_valid_q, out_jump_q, out_ebreak_q, out_invalid_q;
  logic [XLEN-1:0] out_result_q, out_dnpc_q;

  logic [OP_W-1:0] op_raw;
  op_e             op;
  logic [XLEN-1:0] a, b, pc;
  logic [SHW-1:0]  sh;

  assign op_raw = bus.in_op;
  assign op     = op_e'(op_raw[4:0]);
  assign a      = bus.in_src1;
  assign b      = bus.in_src2;
  assign pc     = bus.in_pc;
  assign sh     = b[SHW-1:0];

  logic [XLEN-1:0] alu_result, alu_dnpc;
  logic            alu_jump, alu_ebreak, alu_invalid;

  always_comb begin
    alu_result  = '0;
    alu_dnpc    = '0;
    alu_jump    = 1'b0;
    alu_ebreak  = 1'b0;
    alu_invalid = 1'b0;
    case (op)
      OP_ADD:   alu_result = a + b;
      OP_SUB:   alu_result = a - b;
      OP_AND:   alu_result = a & b;
      OP_OR:    alu_result = a | b;
      OP_XOR:   alu_result = a ^ b;
      OP_SLL:   alu_result = a << sh;
      OP_SRL:   alu_result = a >> sh;
      OP_SRA:   alu_result = $signed(a) >>> sh;
      OP_SLT:   alu_result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:  alu_result = {{(XLEN-1){1'b0}}, (a < b)};
      OP_AUIPC: alu_result = a + pc;
      OP_LUI:   alu_result = a;
      OP_JAL: begin
        alu_result = pc + XLEN'(4);
        alu_dnpc   = pc + a;
        alu_jump   = 1'b1;
      end
      OP_JALR: begin
        alu_result = pc + XLEN'(4);
        alu_dnpc   = (a + b) & ~XLEN'(1);
        alu_jump   = 1'b1;
      end
      OP_EBREAK: alu_ebreak = 1'b1;
      OP_SD, OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU: alu_result = '0;
      default:  alu_invalid = 1'b1;
    endcase
  end

  // Shift-add multiply, STEP_BITS multiplier bits consumed per cycle.
  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < STEP_BITS; i++) begin
      if (mplier_q[i]) acc_d = acc_d + (mcand_q << i);
    end
    mcand_d  = mcand_q << STEP_BITS;
    mplier_d = mplier_q >> STEP_BITS;
  end

  logic            div_start, div_signed, div_done;
  logic [XLEN-1:0] div_quot, div_rem;

  // Gated by ~flush so an accept coinciding with flush never launches the divider.
  assign div_start  = (state_q == ST_IDLE) & bus.in_valid & ~flush &
                      is_multicycle(op) & (op != OP_MUL);
  assign div_signed = (op == OP_DIV) || (op == OP_REM);

  exu_divider #(
    .XLEN      (XLEN),
    .STEP_BITS (STEP_BITS)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .abort_i    (flush),
    .start_i    (div_start),
    .signed_i   (div_signed),
    .dividend_i (a),
    .divisor_i  (b),
    .done_o     (div_done),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      acc_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      rem_sel_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_dnpc_q    <= '0;
      out_jump_q    <= 1'b0;
      out_ebreak_q  <= 1'b0;
      out_invalid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.in_valid) begin
          out_dnpc_q    <= alu_dnpc;
          out_jump_q    <= alu_jump;
          out_ebreak_q  <= alu_ebreak;
          out_invalid_q <= alu_invalid;
          cnt_q         <= '0;
          if (op == OP_MUL) begin
            state_q  <= ST_MUL;
            acc_q    <= '0;
            mcand_q  <= a;
            mplier_q <= b;
          end else if (is_multicycle(op)) begin
            state_q   <= ST_DIV;
            rem_sel_q <= (op == OP_REM) || (op == OP_REMU);
          end else begin
            state_q      <= ST_DONE;
            out_valid_q  <= 1'b1;
            out_result_q <= alu_result;
          end
        end
        ST_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          if (cnt_q == CW'(N_ITER - 1)) begin
            state_q      <= ST_DONE;
            out_valid_q  <= 1'b1;
            out_result_q <= acc_d;
            cnt_q        <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DIV: if (div_done) begin
          state_q      <= ST_DONE;
          out_valid_q  <= 1'b1;
          out_result_q <= rem_sel_q ? div_rem : div_quot;
        end
        ST_DONE: if (bus.out_ready) begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state_q == ST_IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_dnpc    = out_dnpc_q;
  assign bus.out_jump    = out_jump_q;
  assign bus.out_ebreak  = out_ebreak_q;
  assign bus.out_invalid = out_invalid_q;
  assign busy            = (state_q == ST_MUL) || (state_q == ST_DIV);
endmodule
